// File: rtl/restador_pkg.sv
// Shared definitions for the 3-bit subtractor board controller.
//   estado_t : sequencer states (ESPERA_A, ESPERA_B, CALCULA, MUESTRA)
//   seg7()   : 0..7 to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
package restador_pkg;

  typedef enum logic [1:0] {
    ESPERA_A = 2'd0,
    ESPERA_B = 2'd1,
    CALCULA  = 2'd2,
    MUESTRA  = 2'd3
  } estado_t;

  function automatic logic [6:0] seg7(input logic [2:0] valor);
    logic [6:0] patron;
    patron = 7'h7f;
    case (valor)
      3'd0: patron = 7'h40;
      3'd1: patron = 7'h79;
      3'd2: patron = 7'h24;
      3'd3: patron = 7'h30;
      3'd4: patron = 7'h19;
      3'd5: patron = 7'h12;
      3'd6: patron = 7'h02;
      3'd7: patron = 7'h78;
      default: patron = 7'h7f;
    endcase
    return patron;
  endfunction

endpackage

// File: rtl/pulso_boton.sv
// Turns a raw asynchronous pushbutton into a single-cycle pulse on its
// accepted rising edge: 2-flop synchronizer, optional debounce, edge detect.
//   clk      : system clock
//   rst      : asynchronous reset, active-high
//   btn      : raw button level, active-high, asynchronous to clk
//   pulso    : one-cycle pulse per accepted press
// Build option CONTROL_REBOTE_EN: the synchronized level must hold for
// N_REBOTE consecutive samples before it is accepted. Without it the edge
// detector works directly on the synchronized level.
module pulso_boton #(
  parameter int unsigned N_REBOTE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulso
);

  logic sinc_1;
  logic sinc_2;
  logic nivel;
  logic nivel_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sinc_1 <= '0;
      sinc_2 <= '0;
    end else begin
      sinc_1 <= btn;
      sinc_2 <= sinc_1;
    end
  end

`ifdef CONTROL_REBOTE_EN
  localparam int unsigned CW = (N_REBOTE > 1) ? $clog2(N_REBOTE) : 1;

  logic [CW-1:0] cuenta;
  logic          estable;

  // cuenta tracks how many consecutive samples disagree with the accepted
  // level; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta  <= '0;
      estable <= '0;
    end else if (sinc_2 == estable) begin
      cuenta <= '0;
    end else if (cuenta == CW'(N_REBOTE - 1)) begin
      estable <= sinc_2;
      cuenta  <= '0;
    end else begin
      cuenta <= cuenta + CW'(1);
    end
  end

  assign nivel = estable;
`else
  logic unused_n_rebote;
  assign unused_n_rebote = ^N_REBOTE;
  assign nivel = sinc_2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nivel_prev <= '0;
    end else begin
      nivel_prev <= nivel;
    end
  end

  assign pulso = nivel & ~nivel_prev;

endmodule

// File: rtl/control_restador.sv
// Sequencer for the 3-bit subtractor board. Captures operand A then operand B
// from the switches on "cargar" presses, lets the external subtractor settle
// for one cycle, latches |A-B| plus a sign flag and shows it on one digit.
//   clk, rst    : clock / asynchronous active-high reset
//   sw          : operand switches
//   btn_cargar  : raw load/next button     btn_borrar : raw clear button
//   op_a, op_b  : registered operands to the subtractor
//   dif         : subtractor result (op_a - op_b) mod 2^ANCHO
//   resultado   : latched magnitude        negativo   : 1 when A < B
//   listo       : 1 while the result is displayed
//   seg         : active-low 7-seg {g,f,e,d,c,b,a}; sw while entering operands,
//                 op_b during CALCULA, resultado in MUESTRA
// Build option CONTROL_REBOTE_EN enables button debounce (N_REBOTE samples).
module control_restador
  import restador_pkg::*;
#(
  parameter int unsigned ANCHO    = 3,
  parameter int unsigned N_REBOTE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] sw,
  input  logic             btn_cargar,
  input  logic             btn_borrar,
  output logic [ANCHO-1:0] op_a,
  output logic [ANCHO-1:0] op_b,
  input  logic [ANCHO-1:0] dif,
  output logic [ANCHO-1:0] resultado,
  output logic             negativo,
  output logic             listo,
  output logic [6:0]       seg
);

  estado_t          estado;
  logic             p_cargar;
  logic             p_borrar;
  logic             menor;
  logic [ANCHO-1:0] magnitud;

  pulso_boton #(.N_REBOTE(N_REBOTE)) u_pulso_cargar (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_cargar),
    .pulso (p_cargar)
  );

  pulso_boton #(.N_REBOTE(N_REBOTE)) u_pulso_borrar (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_borrar),
    .pulso (p_borrar)
  );

  // Sign comes from the operands themselves; the two's-complement negation
  // of the wrapped difference gives the magnitude when A < B.
  assign menor    = (op_a < op_b);
  assign magnitud = menor ? ((~dif) + ANCHO'(1)) : dif;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= ESPERA_A;
      op_a      <= '0;
      op_b      <= '0;
      resultado <= '0;
      negativo  <= '0;
      listo     <= '0;
    end else if (p_borrar) begin
      estado    <= ESPERA_A;
      op_a      <= '0;
      op_b      <= '0;
      resultado <= '0;
      negativo  <= '0;
      listo     <= '0;
    end else begin
      case (estado)
        ESPERA_A: begin
          if (p_cargar) begin
            op_a   <= sw;
            estado <= ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (p_cargar) begin
            op_b   <= sw;
            estado <= CALCULA;
          end
        end
        CALCULA: begin
          negativo  <= menor;
          resultado <= magnitud;
          listo     <= 1'b1;
          estado    <= MUESTRA;
        end
        MUESTRA: begin
          if (p_cargar) begin
            listo  <= 1'b0;
            estado <= ESPERA_A;
          end
        end
        default: begin
          listo  <= 1'b0;
          estado <= ESPERA_A;
        end
      endcase
    end
  end

  always_comb begin
    seg = 7'h7f;
    case (estado)
      ESPERA_A, ESPERA_B: seg = seg7(sw[2:0]);
      CALCULA:            seg = seg7(op_b[2:0]);
      MUESTRA:            seg = seg7(resultado[2:0]);
      default:            seg = 7'h7f;
    endcase
  end

endmodule

// File: tb/tb_control_restador.sv
module tb_control_restador;

  localparam int unsigned ANCHO = 3;
`ifdef CONTROL_REBOTE_EN
  localparam int unsigned N_REB = 16;
  localparam int          CAP   = 3 + N_REB;
`else
  localparam int unsigned N_REB = 16;
  localparam int          CAP   = 3;
`endif
  localparam int HOLD = CAP + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ANCHO-1:0] sw = '0;
  logic             btn_cargar = 1'b0;
  logic             btn_borrar = 1'b0;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
  logic [ANCHO-1:0] dif;
  logic [ANCHO-1:0] resultado;
  logic             negativo;
  logic             listo;
  logic [6:0]       seg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // external combinational subtractor
  assign dif = op_a - op_b;

  control_restador #(.ANCHO(ANCHO), .N_REBOTE(N_REB)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn_cargar (btn_cargar),
    .btn_borrar (btn_borrar),
    .op_a       (op_a),
    .op_b       (op_b),
    .dif        (dif),
    .resultado  (resultado),
    .negativo   (negativo),
    .listo      (listo),
    .seg        (seg)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] res;
    logic       neg;
    logic [6:0] segm;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] seg_ref(input logic [2:0] v);
    logic [6:0] t[8];
    t[0] = 7'h40; t[1] = 7'h79; t[2] = 7'h24; t[3] = 7'h30;
    t[4] = 7'h19; t[5] = 7'h12; t[6] = 7'h02; t[7] = 7'h78;
    return t[v];
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic press_cargar(input logic [2:0] v);
    @(negedge clk);
    sw = v;
    btn_cargar = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_cargar = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3'd6, 3'd4, 3'd2, 1'b0, 7'h24};
    vecs[1] = '{3'd3, 3'd4, 3'd1, 1'b1, 7'h79};
    vecs[2] = '{3'd5, 3'd5, 3'd0, 1'b0, 7'h40};
    vecs[3] = '{3'd0, 3'd7, 3'd7, 1'b1, 7'h78};
    vecs[4] = '{3'd7, 3'd0, 3'd7, 1'b0, 7'h78};
    vecs[5] = '{3'd1, 3'd6, 3'd5, 1'b1, 7'h12};
    vecs[6] = '{3'd2, 3'd7, 3'd5, 1'b1, 7'h12};
    vecs[7] = '{3'd4, 3'd1, 3'd3, 1'b0, 7'h30};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_op_a", 8'(op_a), 8'd0);
    chk("rst_op_b", 8'(op_b), 8'd0);
    chk("rst_res", 8'(resultado), 8'd0);
    chk("rst_neg", 8'(negativo), 8'd0);
    chk("rst_listo", 8'(listo), 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_seg", 8'(seg), 8'(7'h40));

    // exact capture / result latency, A=6 B=4
    press_cargar(3'd6);
    chk("lat_op_a", 8'(op_a), 8'd6);
    @(negedge clk);
    sw = 3'd4;
    btn_cargar = 1'b1;
    repeat (CAP - 1) @(posedge clk);
    #1;
    chk("lat_op_b_early", 8'(op_b), 8'd0);
    @(posedge clk); #1;
    chk("lat_op_b", 8'(op_b), 8'd4);
    chk("lat_listo_calc", 8'(listo), 8'd0);
    chk("lat_seg_calc", 8'(seg), 8'(7'h19));
    @(posedge clk); #1;
    chk("lat_listo", 8'(listo), 8'd1);
    chk("lat_res", 8'(resultado), 8'd2);
    chk("lat_neg", 8'(negativo), 8'd0);
    chk("lat_seg", 8'(seg), 8'(7'h24));
    @(negedge clk);
    btn_cargar = 1'b0;
    repeat (HOLD) @(negedge clk);
    press_cargar(3'd0);
    chk("lat_back_listo", 8'(listo), 8'd0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      press_cargar(vecs[i].a);
      press_cargar(vecs[i].b);
      chk($sformatf("v%0d_op_a", i), 8'(op_a), 8'(vecs[i].a));
      chk($sformatf("v%0d_op_b", i), 8'(op_b), 8'(vecs[i].b));
      chk($sformatf("v%0d_res", i), 8'(resultado), 8'(vecs[i].res));
      chk($sformatf("v%0d_neg", i), 8'(negativo), 8'(vecs[i].neg));
      chk($sformatf("v%0d_listo", i), 8'(listo), 8'd1);
      chk($sformatf("v%0d_seg", i), 8'(seg), 8'(vecs[i].segm));
      press_cargar(3'd0);
      chk($sformatf("v%0d_listo_off", i), 8'(listo), 8'd0);
      sw = 3'(i + 3);
      #1;
      chk($sformatf("v%0d_seg_live", i), 8'(seg), 8'(seg_ref(3'(i + 3))));
    end

    // held operands after returning to ESPERA_A (last vector 4,1)
    chk("hold_op_a", 8'(op_a), 8'd4);
    chk("hold_res", 8'(resultado), 8'd3);

    // borrar + cargar together in ESPERA_B
    press_cargar(3'd5);
    chk("clr_pre_op_a", 8'(op_a), 8'd5);
    @(negedge clk);
    sw = 3'd6;
    btn_cargar = 1'b1;
    btn_borrar = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("clr_op_a", 8'(op_a), 8'd0);
    chk("clr_op_b", 8'(op_b), 8'd0);
    chk("clr_res", 8'(resultado), 8'd0);
    chk("clr_listo", 8'(listo), 8'd0);
    press_cargar(3'd2);
    chk("clr_state_a", 8'(op_a), 8'd2);
    chk("clr_state_b", 8'(op_b), 8'd0);

    // rst while in CALCULA
    @(negedge clk);
    sw = 3'd1;
    btn_cargar = 1'b1;
    repeat (CAP) @(posedge clk);
    #1;
    chk("rstc_in_calc", 8'(op_b), 8'd1);
    rst = 1'b1;
    #1;
    chk("rstc_op_a", 8'(op_a), 8'd0);
    chk("rstc_op_b", 8'(op_b), 8'd0);
    chk("rstc_res", 8'(resultado), 8'd0);
    chk("rstc_neg", 8'(negativo), 8'd0);
    chk("rstc_listo", 8'(listo), 8'd0);
    chk("rstc_seg", 8'(seg), 8'(7'h79));
    @(negedge clk);
    btn_cargar = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("rstc_no_capture", 8'(op_a), 8'd0);
    press_cargar(3'd6);
    chk("rstc_after_a", 8'(op_a), 8'd6);
    chk("rstc_after_b", 8'(op_b), 8'd0);

`ifdef CONTROL_REBOTE_EN
    // bouncing button: only the final stable level is accepted
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sw = 3'd3;
    for (int k = 0; k < 6; k++) begin
      btn_cargar = ~btn_cargar;
      repeat (3) @(negedge clk);
    end
    chk("reb_no_capture", 8'(op_a), 8'd0);
    btn_cargar = 1'b1;
    repeat (CAP - 1) @(posedge clk);
    #1;
    chk("reb_early", 8'(op_a), 8'd0);
    @(posedge clk); #1;
    chk("reb_capture", 8'(op_a), 8'd3);
    sw = 3'd5;
    repeat (40) @(negedge clk);
    chk("reb_single", 8'(op_b), 8'd0);
    btn_cargar = 1'b0;
    repeat (HOLD) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
